// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing_gen (master) and the tile/text layer (slave).
// o_frame_count exists only when VGA_TIMING_FRAME_COUNT_EN is defined.
interface vga_timing_if;
  logic [15:0] o_horz_coord;
  logic [15:0] o_vert_coord;
  logic        o_in_active_area;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_line_start;
  logic        o_frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] o_frame_count;
`endif

  modport master (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    output o_frame_count,
`endif
    output o_horz_coord,
    output o_vert_coord,
    output o_in_active_area,
    output o_hsync,
    output o_vsync,
    output o_line_start,
    output o_frame_start
  );

  modport slave (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    input o_frame_count,
`endif
    input o_horz_coord,
    input o_vert_coord,
    input o_in_active_area,
    input o_hsync,
    input o_vsync,
    input o_line_start,
    input o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: coordinates, active flag, syncs and line/frame strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic         i_pix_clk,
  input  logic         i_reset,
  vga_timing_if.master vga
);

  localparam int unsigned CW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  // IDLE covers reset; the first edge out of it emits (0,0) rather than incrementing.
  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] horz_q, horz_d;
  logic [CW-1:0] vert_q, vert_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [CW-1:0] fcnt_q, fcnt_d;
`endif

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      horz_q   <= '0;
      vert_q   <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      fcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      horz_q   <= horz_d;
      vert_q   <= vert_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      fcnt_q   <= fcnt_d;
`endif
    end
  end

  // Next counts first; every flag is decoded from them so all outputs stay aligned.
  always_comb begin
    state_d = state_q;
    horz_d  = horz_q;
    vert_d  = vert_q;

    if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      horz_d  = '0;
      vert_d  = '0;
    end else if (horz_q == H_LAST) begin
      horz_d = '0;
      vert_d = (vert_q == V_LAST) ? '0 : vert_q + 1'b1;
    end else begin
      horz_d = horz_q + 1'b1;
    end

    active_d = (horz_d < H_ACT_C) && (vert_d < V_ACT_C);
    hsync_d  = ((horz_d >= HS_BEG) && (horz_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = ((vert_d >= VS_BEG) && (vert_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_d   = (horz_d == '0);
    frame_d  = line_d && (vert_d == '0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
    fcnt_d = fcnt_q;
    if ((state_q == ST_RUN) && frame_d) begin
      fcnt_d = fcnt_q + 1'b1;
    end
`endif
  end

  assign vga.o_horz_coord     = horz_q;
  assign vga.o_vert_coord     = vert_q;
  assign vga.o_in_active_area = active_q;
  assign vga.o_hsync          = hsync_q;
  assign vga.o_vsync          = vsync_q;
  assign vga.o_line_start     = line_q;
  assign vga.o_frame_start    = frame_q;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  assign vga.o_frame_count    = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance checked against a checkpoint table,
// reduced-size instance checked every cycle through a closed-form scoreboard.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    int unsigned n;
    obs_t        exp;
  } vec_t;

  // Reduced geometry: 16 x 13 = 208 cycles per frame
  localparam int unsigned S_HT = 16;
  localparam int unsigned S_VT = 13;
  localparam int unsigned S_FRAME = S_HT * S_VT;
  localparam int unsigned RUN_N = 1700;

  logic clk;
  logic rst_d;
  logic rst_s;
  int   checks;
  int   failures;

  vga_timing_if vga_d ();
  vga_timing_if vga_s ();

  vga_timing_gen dut (
    .i_pix_clk (clk),
    .i_reset   (rst_d),
    .vga       (vga_d)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_ACTIVE (1'b0)
  ) dut_s (
    .i_pix_clk (clk),
    .i_reset   (rst_s),
    .vga       (vga_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(int unsigned h, int unsigned v, bit a, bit hs, bit vs, bit ls, bit fs);
    obs_t o;
    o.h = 16'(h); o.v = 16'(v);
    o.act = a; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic obs_t model_s(int unsigned n);
    int unsigned h, v;
    h = n % S_HT;
    v = (n / S_HT) % S_VT;
    return mk(h, v, (h < 8) && (v < 6), !((h >= 10) && (h < 13)), !((v >= 8) && (v < 10)),
              h == 0, (h == 0) && (v == 0));
  endfunction

  function automatic obs_t get_d();
    return mk(vga_d.o_horz_coord, vga_d.o_vert_coord, vga_d.o_in_active_area,
              vga_d.o_hsync, vga_d.o_vsync, vga_d.o_line_start, vga_d.o_frame_start);
  endfunction

  function automatic obs_t get_s();
    return mk(vga_s.o_horz_coord, vga_s.o_vert_coord, vga_s.o_in_active_area,
              vga_s.o_hsync, vga_s.o_vsync, vga_s.o_line_start, vga_s.o_frame_start);
  endfunction

  task automatic check_obs(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got h=%0d v=%0d a=%b hs=%b vs=%b ls=%b fs=%b expected h=%0d v=%0d a=%b hs=%b vs=%b ls=%b fs=%b",
               name, got.h, got.v, got.act, got.hs, got.vs, got.ls, got.fs,
               exp.h, exp.v, exp.act, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  vec_t tbl[12];
  obs_t sb_q[$];
  obs_t rst_obs;

  // Cycle-by-cycle scoreboard on the reduced instance for n edges after release
  task automatic run_s_only(int unsigned cycles);
    obs_t e;
    for (int unsigned n = 0; n < cycles; n++) begin
      sb_q.push_back(model_s(n));
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check_int("sb_underflow", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check_obs("sb_restart", get_s(), e);
      end
    end
  endtask

  initial begin
    obs_t        e;
    obs_t        got_d;
    obs_t        got_s;
    int unsigned ti;
    int          hs_low;
    int          hs_first;
    int          vs_low;
    int          last_ls;
    int          last_fs;
    int          fs_d_cnt;
    bit          found;

    checks   = 0;
    failures = 0;
    rst_obs  = mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    tbl[0]  = '{0,    mk(0,   0, 1, 1, 1, 1, 1)};
    tbl[1]  = '{639,  mk(639, 0, 1, 1, 1, 0, 0)};
    tbl[2]  = '{640,  mk(640, 0, 0, 1, 1, 0, 0)};
    tbl[3]  = '{655,  mk(655, 0, 0, 1, 1, 0, 0)};
    tbl[4]  = '{656,  mk(656, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{751,  mk(751, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{752,  mk(752, 0, 0, 1, 1, 0, 0)};
    tbl[7]  = '{799,  mk(799, 0, 0, 1, 1, 0, 0)};
    tbl[8]  = '{800,  mk(0,   1, 1, 1, 1, 1, 0)};
    tbl[9]  = '{801,  mk(1,   1, 1, 1, 1, 0, 0)};
    tbl[10] = '{1439, mk(639, 1, 1, 1, 1, 0, 0)};
    tbl[11] = '{1600, mk(0,   2, 1, 1, 1, 1, 0)};

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    check_obs("reset_d", get_d(), rst_obs);
    check_obs("reset_s", get_s(), rst_obs);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check_int("reset_fcnt", int'(vga_s.o_frame_count), 0);
`endif

    rst_d = 1'b0;
    rst_s = 1'b0;
    ti       = 0;
    hs_low   = 0;
    hs_first = -1;
    vs_low   = 0;
    last_ls  = -1;
    last_fs  = -1;
    fs_d_cnt = 0;

    for (int unsigned n = 0; n < RUN_N; n++) begin
      sb_q.push_back(model_s(n));
      @(negedge clk);
      got_d = get_d();
      got_s = get_s();

      if (ti < 12 && tbl[ti].n == n) begin
        check_obs($sformatf("tbl_n%0d", n), got_d, tbl[ti].exp);
        ti++;
      end
      if (n < 800 && got_d.hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(n);
      end
      if (got_d.ls) begin
        if (last_ls >= 0) check_int("line_period", int'(n) - last_ls, 800);
        last_ls = int'(n);
      end
      if (got_d.fs) fs_d_cnt++;

      if (sb_q.size() == 0) begin
        check_int("sb_underflow", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check_obs("sb_small", got_s, e);
      end
      if (n < 8 * S_FRAME && got_s.vs == 1'b0) vs_low++;
      if (got_s.fs) begin
        if (last_fs >= 0) check_int("frame_period_s", int'(n) - last_fs, int'(S_FRAME));
        last_fs = int'(n);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check_int("fcnt_s", int'(vga_s.o_frame_count), int'(n / S_FRAME));
`endif
      end
    end

    check_int("tbl_all_hit", int'(ti), 12);
    check_int("hsync_low_cycles", hs_low, 96);
    check_int("hsync_first_low", hs_first, 656);
    check_int("frame_start_d_once", fs_d_cnt, 1);
    check_int("vsync_low_cycles_s", vs_low, 8 * 2 * int'(S_HT));

    // Find (10,7) on the reduced instance, then slam reset on both mid-frame
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (vga_s.o_horz_coord == 16'd10 && vga_s.o_vert_coord == 16'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_int("find_10_7", int'(found), 1);

    rst_d = 1'b1;
    rst_s = 1'b1;
    #1;
    check_obs("async_reset_d", get_d(), rst_obs);
    check_obs("async_reset_s", get_s(), rst_obs);
    @(negedge clk);
    check_obs("held_reset_d", get_d(), rst_obs);
    check_obs("held_reset_s", get_s(), rst_obs);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check_int("fcnt_after_reset", int'(vga_s.o_frame_count), 0);
`endif

    rst_d = 1'b0;
    rst_s = 1'b0;
    sb_q.delete();
    run_s_only(40);
    // run_s_only covered 40 edges; full-size instance is now at n=39
    check_obs("restart_d", get_d(), mk(39, 0, 1, 1, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
